// File: rtl/order_axi_sender.sv
// Purpose : queues order requests and streams ORDER_LEN samples per order from a FWFT buffer onto an AXI-Stream
// Latency : 1 cycle from buf_rd to axi_tvalid; one IDLE cycle separates consecutive orders
// Backpr. : axi_tready=0 holds the output beat and stops popping; buf_valid=0 stalls the order indefinitely
// Ports   : clk/rst (async, active-high); order_come request pulse; buf_valid/buf_data/buf_rd upstream FWFT pop;
//           axi_tdata/axi_tvalid/axi_tready/axi_tlast stream; order_full/order_drop/sending/no_order/pending status
module order_axi_sender #(
    parameter int DATA_W     = 25,
    parameter int ORDER_LEN  = 50,
    parameter int MAX_ORDERS = 5,
    parameter int CNT_W      = $clog2(MAX_ORDERS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              order_come,
    input  logic              buf_valid,
    input  logic [DATA_W-1:0] buf_data,
    output logic              buf_rd,
    output logic [DATA_W-1:0] axi_tdata,
    output logic              axi_tvalid,
    input  logic              axi_tready,
    output logic              axi_tlast,
    output logic              order_full,
    output logic              order_drop,
    output logic              sending,
    output logic              no_order,
    output logic [CNT_W-1:0]  pending
);

    localparam int ISS_W = $clog2(ORDER_LEN + 1);
    localparam logic [CNT_W-1:0] MAX_C  = CNT_W'(MAX_ORDERS);
    localparam logic [ISS_W-1:0] LEN_C  = ISS_W'(ORDER_LEN);
    localparam logic [ISS_W-1:0] LAST_C = ISS_W'(ORDER_LEN - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t              state_q;
    logic [CNT_W-1:0]    pending_q;
    logic [CNT_W-1:0]    pending_d;
    logic [ISS_W-1:0]    issued_q;
    logic [DATA_W-1:0]   tdata_q;
    logic                tvalid_q;
    logic                tlast_q;
    logic                order_drop_q;
    logic                last_hs;
    logic                accept;

    // A full queue may still take a request in the cycle a slot is freed by the last beat.
    always_comb begin
        last_hs   = tvalid_q & axi_tready & tlast_q;
        accept    = order_come & ((pending_q < MAX_C) | last_hs);
        pending_d = pending_q;
        if (accept && !last_hs) begin
            pending_d = pending_q + CNT_W'(1);
        end else if (!accept && last_hs) begin
            pending_d = pending_q - CNT_W'(1);
        end
    end

    // Pop only when the output register is empty or being drained this cycle.
    assign buf_rd = buf_valid & (state_q == STREAM) & (issued_q < LEN_C) & (~tvalid_q | axi_tready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            pending_q    <= '0;
            issued_q     <= '0;
            tdata_q      <= '0;
            tvalid_q     <= 1'b0;
            tlast_q      <= 1'b0;
            order_drop_q <= 1'b0;
        end else begin
            pending_q    <= pending_d;
            order_drop_q <= order_come & ~accept;

            case (state_q)
                IDLE: begin
                    issued_q <= '0;
                    if (pending_q != '0) begin
                        state_q <= STREAM;
                    end
                end
                STREAM: begin
                    // The last beat can only handshake after all ORDER_LEN pops, so no pop competes here.
                    if (last_hs) begin
                        state_q  <= IDLE;
                        issued_q <= '0;
                    end else if (buf_rd) begin
                        issued_q <= issued_q + ISS_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (buf_rd) begin
                tdata_q  <= buf_data;
                tvalid_q <= 1'b1;
                tlast_q  <= (issued_q == LAST_C);
            end else if (axi_tready) begin
                tvalid_q <= 1'b0;
                tlast_q  <= 1'b0;
            end
        end
    end

    assign axi_tdata  = tdata_q;
    assign axi_tvalid = tvalid_q;
    assign axi_tlast  = tlast_q;
    assign order_drop = order_drop_q;
    assign pending    = pending_q;
    assign sending    = (state_q == STREAM);
    assign order_full = (pending_q == MAX_C);
    assign no_order   = (pending_q == '0);

endmodule

// File: tb/tb_order_axi_sender.sv
// Purpose : self-checking bench for order_axi_sender with a queue-based stream/pending reference model
// Latency : n/a (bench)
// Backpr. : drives random axi_tready and buf_valid gaps
module tb_order_axi_sender;

    localparam int DATA_W     = 25;
    localparam int ORDER_LEN  = 50;
    localparam int MAX_ORDERS = 5;
    localparam int CNT_W      = $clog2(MAX_ORDERS + 1);

    logic              clk;
    logic              rst;
    logic              order_come;
    logic              buf_valid;
    logic [DATA_W-1:0] buf_data;
    logic              buf_rd;
    logic [DATA_W-1:0] axi_tdata;
    logic              axi_tvalid;
    logic              axi_tready;
    logic              axi_tlast;
    logic              order_full;
    logic              order_drop;
    logic              sending;
    logic              no_order;
    logic [CNT_W-1:0]  pending;

    order_axi_sender #(
        .DATA_W(DATA_W), .ORDER_LEN(ORDER_LEN), .MAX_ORDERS(MAX_ORDERS), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .order_come(order_come), .buf_valid(buf_valid),
        .buf_data(buf_data), .buf_rd(buf_rd), .axi_tdata(axi_tdata), .axi_tvalid(axi_tvalid),
        .axi_tready(axi_tready), .axi_tlast(axi_tlast), .order_full(order_full),
        .order_drop(order_drop), .sending(sending), .no_order(no_order), .pending(pending)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model state
    int                exp_pending = 0;
    bit                exp_drop    = 0;
    int                beat_cnt    = 0;
    int                completed   = 0;
    int                total_beats = 0;
    int                drop_cnt    = 0;
    int                cyc         = 0;
    int                first_cyc   = 0;
    int                span        = 0;
    bit                prev_stall  = 0;
    bit                prev_last   = 0;
    bit                prev_tlast  = 0;
    logic [DATA_W-1:0] prev_tdata  = '0;
    bit                pop_seen    = 0;
    bit                hs, last, acc;
    logic [DATA_W-1:0] exp_q[$];

    // Upstream FWFT buffer: a fresh random sample appears after every pop.
    initial begin
        buf_data = DATA_W'($urandom);
        forever begin
            @(posedge clk);
            #1;
            if (pop_seen) begin
                buf_data = DATA_W'($urandom);
                pop_seen = 0;
            end
        end
    end

    // Monitor and scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            exp_pending = 0;
            exp_drop    = 0;
            beat_cnt    = 0;
            exp_q.delete();
            prev_stall  = 0;
            prev_last   = 0;
        end else begin
            chk("pending", 32'(pending), 32'(exp_pending));
            chk("order_drop", 32'(order_drop), 32'(exp_drop));
            chk("order_full", 32'(order_full), 32'(exp_pending == MAX_ORDERS));
            chk("no_order", 32'(no_order), 32'(exp_pending == 0));
            if (!buf_valid) chk("rd_without_valid", 32'(buf_rd), 32'd0);
            if (buf_rd) chk("rd_outside_stream", 32'(sending), 32'd1);
            if (prev_last) begin
                chk("gap_sending", 32'(sending), 32'd0);
                chk("gap_rd", 32'(buf_rd), 32'd0);
            end
            if (prev_stall) begin
                chk("stall_tvalid", 32'(axi_tvalid), 32'd1);
                chk("stall_tdata", 32'(axi_tdata), 32'(prev_tdata));
                chk("stall_tlast", 32'(axi_tlast), 32'(prev_tlast));
            end
            hs   = axi_tvalid && axi_tready;
            last = hs && (beat_cnt == ORDER_LEN - 1);
            if (hs) begin
                chk("beat_has_source", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) chk("tdata_order", 32'(axi_tdata), 32'(exp_q.pop_front()));
                chk("tlast_pos", 32'(axi_tlast), 32'(last));
                if (beat_cnt == 0) first_cyc = cyc;
                beat_cnt++;
                total_beats++;
                if (last) begin
                    span     = cyc - first_cyc + 1;
                    beat_cnt = 0;
                    completed++;
                end
            end
            if (buf_rd) begin
                exp_q.push_back(buf_data);
                pop_seen = 1;
            end
            acc         = order_come && ((exp_pending < MAX_ORDERS) || last);
            exp_drop    = order_come && !acc;
            exp_pending = exp_pending + int'(acc) - int'(last);
            if (order_drop) drop_cnt++;
            prev_stall = axi_tvalid && !axi_tready;
            prev_tdata = axi_tdata;
            prev_tlast = axi_tlast;
            prev_last  = last;
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_order();
        order_come = 1'b1;
        tick();
        order_come = 1'b0;
        tick();
    endtask

    bit ok;

    initial begin
        rst        = 1'b1;
        order_come = 1'b0;
        buf_valid  = 1'b0;
        axi_tready = 1'b0;
        #3;
        chk("rst_tvalid", 32'(axi_tvalid), 32'd0);
        chk("rst_tlast", 32'(axi_tlast), 32'd0);
        chk("rst_tdata", 32'(axi_tdata), 32'd0);
        chk("rst_buf_rd", 32'(buf_rd), 32'd0);
        chk("rst_sending", 32'(sending), 32'd0);
        chk("rst_no_order", 32'(no_order), 32'd1);
        chk("rst_pending", 32'(pending), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Single order, free-flowing source and sink.
        buf_valid  = 1'b1;
        axi_tready = 1'b1;
        order_come = 1'b1;
        tick();
        order_come = 1'b0;
        chk("one_pending_after_req", 32'(pending), 32'd1);
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (completed == 1 && no_order && !sending && !axi_tvalid) begin ok = 1; break; end
        end
        chk("one_order_done", 32'(ok), 32'd1);
        chk("one_order_span", 32'(span), 32'(ORDER_LEN));
        chk("one_order_beats", 32'(total_beats), 32'(ORDER_LEN));

        // Six requests with the source empty: the queue fills and the sixth is dropped.
        buf_valid = 1'b0;
        drop_cnt  = 0;
        for (int k = 0; k < 6; k++) pulse_order();
        tick();
        chk("fill_pending", 32'(pending), 32'(MAX_ORDERS));
        chk("fill_full", 32'(order_full), 32'd1);
        chk("fill_drops", 32'(drop_cnt), 32'd1);

        // Request arriving together with the last-beat handshake on a full queue.
        drop_cnt  = 0;
        buf_valid = 1'b1;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (axi_tvalid && axi_tlast) begin ok = 1; break; end
        end
        chk("full_last_beat_seen", 32'(ok), 32'd1);
        order_come = 1'b1;
        tick();
        order_come = 1'b0;
        chk("full_coincide_pending", 32'(pending), 32'(MAX_ORDERS));
        tick();
        tick();
        chk("full_coincide_nodrop", 32'(drop_cnt), 32'd0);

        // Random sink backpressure.
        ok = 0;
        for (int i = 0; i < 2000; i++) begin
            axi_tready = 1'($urandom_range(0, 1));
            tick();
            if (completed >= 4) begin ok = 1; break; end
        end
        chk("random_ready_progress", 32'(ok), 32'd1);

        // Source gap of 10 cycles mid-order.
        ok = 0;
        for (int i = 0; i < 500; i++) begin
            axi_tready = 1'($urandom_range(0, 1));
            tick();
            if (beat_cnt == 20) begin ok = 1; break; end
        end
        chk("gap_reached_beat20", 32'(ok), 32'd1);
        axi_tready = 1'b1;
        buf_valid  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("gap_buf_rd_low", 32'(buf_rd), 32'd0);
        end
        chk("gap_tvalid_drained", 32'(axi_tvalid), 32'd0);
        buf_valid = 1'b1;
        ok = 0;
        for (int i = 0; i < 5000; i++) begin
            axi_tready = 1'($urandom_range(0, 1));
            tick();
            if (no_order && !sending && !axi_tvalid) begin ok = 1; break; end
        end
        chk("drain_done", 32'(ok), 32'd1);
        chk("drain_orders", 32'(completed), 32'd7);
        chk("drain_beats", 32'(total_beats), 32'(7 * ORDER_LEN));
        chk("drain_no_leftover", 32'(exp_q.size()), 32'd0);

        // Reset in the middle of the second of three queued orders.
        axi_tready = 1'b1;
        buf_valid  = 1'b0;
        for (int k = 0; k < 3; k++) pulse_order();
        chk("three_pending", 32'(pending), 32'd3);
        buf_valid = 1'b1;
        ok = 0;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (completed == 8 && beat_cnt == 20) begin ok = 1; break; end
        end
        chk("reset_point_reached", 32'(ok), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_tvalid", 32'(axi_tvalid), 32'd0);
        chk("mid_rst_tlast", 32'(axi_tlast), 32'd0);
        chk("mid_rst_tdata", 32'(axi_tdata), 32'd0);
        chk("mid_rst_buf_rd", 32'(buf_rd), 32'd0);
        chk("mid_rst_sending", 32'(sending), 32'd0);
        chk("mid_rst_pending", 32'(pending), 32'd0);
        chk("mid_rst_no_order", 32'(no_order), 32'd1);
        chk("mid_rst_full", 32'(order_full), 32'd0);
        chk("mid_rst_drop", 32'(order_drop), 32'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("post_rst_pending", 32'(pending), 32'd0);
        chk("post_rst_sending", 32'(sending), 32'd0);
        chk("post_rst_tvalid", 32'(axi_tvalid), 32'd0);
        chk("post_rst_no_order", 32'(no_order), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/order_axi_sender.md
ORDER_AXI_SENDER -- requirements
Module: order_axi_sender

Interface
REQ-001 SHALL have parameter DATA_W, default 25, which sets the sample width.
REQ-002 SHALL have parameter ORDER_LEN, default 50, which sets the samples per order (>=2).
REQ-003 SHALL have parameter MAX_ORDERS, default 5, which sets the pending-order queue capacity (>=1).
REQ-004 SHALL have parameter CNT_W, default $clog2(MAX_ORDERS+1), which sets the pending-count width.
REQ-005 SHALL have port clk, input, width 1: the single clock, all logic on its rising edge.
REQ-006 SHALL have port rst, input, width 1: reset, asynchronous and active-high.
REQ-007 SHALL have port order_come, input, width 1: single-cycle pulse requesting one order.
REQ-008 SHALL have port buf_valid, input, width 1: the upstream buffer has a sample on buf_data (first-word-fall-through).
REQ-009 SHALL have port buf_data, input, width DATA_W: the upstream sample.
REQ-010 SHALL have port buf_rd, output, width 1: pop strobe to the buffer; a sample is consumed when buf_rd=1.
REQ-011 SHALL have port axi_tdata, output, width DATA_W: the stream data to the PS.
REQ-012 SHALL have port axi_tvalid, output, width 1: stream valid.
REQ-013 SHALL have port axi_tready, input, width 1: stream ready.
REQ-014 SHALL have port axi_tlast, output, width 1: marks the final sample of an order.
REQ-015 SHALL have port order_full, output, width 1: pending count equals MAX_ORDERS.
REQ-016 SHALL have port order_drop, output, width 1: one-cycle pulse when an order request is rejected.
REQ-017 SHALL have port sending, output, width 1: FSM is in STREAM.
REQ-018 SHALL have port no_order, output, width 1: pending count equals 0.
REQ-019 SHALL have port pending, output, width CNT_W: registered pending-order count, including the order in progress.

Function
REQ-020 FSM SHALL have states IDLE and STREAM: IDLE->STREAM when pending>0; STREAM->IDLE on the cycle the last beat handshakes (axi_tvalid & axi_tready & axi_tlast).
REQ-021 Order accept SHALL occur when order_come=1 and (pending<MAX_ORDERS or the last-beat handshake occurs in the same cycle); otherwise order_drop=1 next cycle and pending is unchanged.
REQ-022 pending SHALL update next cycle: +1 on accept only, -1 on last-beat handshake only, unchanged when both occur together; it never wraps.
REQ-023 buf_rd SHALL be combinational, equal to buf_valid & (state==STREAM) & (issued<ORDER_LEN) & (!axi_tvalid | axi_tready).
REQ-024 On buf_rd=1, axi_tdata SHALL load buf_data, axi_tvalid SHALL be set to 1, issued SHALL increment, and axi_tlast SHALL be set to (issued==ORDER_LEN-1), all at the next edge.
REQ-025 While axi_tvalid=1 and axi_tready=0, axi_tdata, axi_tvalid and axi_tlast SHALL hold stable.
REQ-026 On a handshake with no new load, axi_tvalid and axi_tlast SHALL clear next cycle.
REQ-027 Throughput SHALL be 1 beat/cycle when buf_valid and axi_tready stay high; latency from buf_rd to axi_tvalid is 1 cycle.
REQ-028 issued (width $clog2(ORDER_LEN+1)) SHALL clear on entry to IDLE; exactly ORDER_LEN beats are emitted per order, with exactly one axi_tlast.
REQ-029 One IDLE cycle SHALL separate consecutive orders; no buffer pop occurs in IDLE.
REQ-030 buf_valid=0 mid-order SHALL stall the order with no timeout; axi_tvalid drops once the held beat is consumed.
REQ-031 order_full, no_order and sending SHALL derive from registered state only.

Reset
REQ-032 rst=1 SHALL immediately force: state IDLE, pending=0, issued=0, axi_tdata=0, axi_tvalid=0, axi_tlast=0, order_drop=0; therefore sending=0, order_full=0, no_order=1, and buf_rd=0.
REQ-033 Reset asserted mid-order SHALL discard the order in progress and all pending orders; no partial-order resume occurs after release.

Verification
REQ-034 One order_come pulse, buf_valid=1 held, axi_tready=1 -> 50 consecutive beats, tlast only on beat 50, pending 1->0, no_order returns to 1.
REQ-035 Six order_come pulses while idle with buf_valid=0 -> pending=5, order_full=1, a single order_drop pulse on the 6th request.
REQ-036 With pending=5, order_come coincides with a last-beat handshake -> request accepted, pending stays 5, no order_drop.
REQ-037 Toggle axi_tready 0/1 randomly -> axi_tdata stable while stalled, no sample lost or duplicated, order of samples preserved.
REQ-038 Toggle buf_valid low for 10 cycles mid-order -> buf_rd=0 throughout the gap, order resumes and the beat count still totals 50.
REQ-039 Assert rst at beat 20 of the 2nd of 3 queued orders -> all outputs at reset values the same cycle, pending=0 after release.
